// File: rtl/arilla_bus_if.sv
// arilla_bus_if: single-outstanding peripheral bus (initiator drives addr/wdata/mask/rd/wr, target returns hit/rdata)
interface arilla_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0] mask;
  logic rd;
  logic wr;
  logic hit;
  modport master (output addr, wdata, mask, rd, wr, input hit, rdata);
  modport slave (input addr, wdata, mask, rd, wr, output hit, rdata);
endinterface

// File: rtl/sba_initiator.sv
// sba_initiator: command-driven bus initiator issuing single or auto-incrementing bursts of byte/half/word beats
module sba_initiator (
  input  logic clk,
  input  logic rst_n,
  arilla_bus_if.master bus,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [1:0] cmd_size,
  input  logic [7:0] cmd_count,
  input  logic cmd_autoinc,
  output logic rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0] rsp_error,
  output logic busy
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] RDATA = 3'd3;
  localparam logic [2:0] RESP = 3'd4;
  logic [2:0] state;
  logic wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0] size_q;
  logic [7:0] cnt_q;
  logic autoinc_q;
  logic [1:0] off;
  logic issue;
  logic misaligned;
  logic [3:0] mask_c;
  logic [31:0] shifted;
  logic [31:0] rd_ext;
  assign off = addr_q[1:0];
  assign issue = state == ISSUE;
  assign misaligned = size_q == 2'd3 || (size_q == 2'd1 && addr_q[0]) || (size_q == 2'd2 && off != 2'd0);
  assign mask_c = size_q == 2'd0 ? 4'b0001 << off : size_q == 2'd1 ? 4'b0011 << off : 4'b1111;
  assign shifted = bus.rdata >> {off, 3'b000};
  assign rd_ext = size_q == 2'd0 ? {24'b0, shifted[7:0]} : size_q == 2'd1 ? {16'b0, shifted[15:0]} : shifted;
  // Bus outputs are decoded from state so they are zero outside ISSUE and drop the instant reset asserts
  assign bus.rd = issue && !wr_q;
  assign bus.wr = issue && wr_q;
  assign bus.addr = issue ? addr_q : 32'b0;
  assign bus.mask = issue ? mask_c : 4'b0;
  assign bus.wdata = issue ? wdata_q << {off, 3'b000} : 32'b0;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_q <= 1'b0;
      addr_q <= 32'b0;
      wdata_q <= 32'b0;
      size_q <= 2'b0;
      cnt_q <= 8'b0;
      autoinc_q <= 1'b0;
      rsp_rdata <= 32'b0;
      rsp_error <= 2'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          wr_q <= cmd_write;
          addr_q <= cmd_addr;
          wdata_q <= cmd_wdata;
          size_q <= cmd_size;
          cnt_q <= cmd_count;
          autoinc_q <= cmd_autoinc;
          state <= CHECK;
        end
        CHECK: begin
          if (misaligned) begin
            rsp_error <= 2'd1;
            rsp_rdata <= 32'b0;
          end
          state <= misaligned ? RESP : ISSUE;
        end
        ISSUE: begin
          if (!bus.hit || wr_q) begin
            rsp_error <= bus.hit ? 2'd0 : 2'd2;
            rsp_rdata <= 32'b0;
          end
          state <= (!bus.hit || wr_q) ? RESP : RDATA;
        end
        RDATA: begin
          rsp_rdata <= rd_ext;
          rsp_error <= 2'd0;
          state <= RESP;
        end
        RESP: begin
          // Any error aborts the rest of the burst; the address wraps naturally at 2^32
          if (rsp_error != 2'd0 || cnt_q == 8'd0) state <= IDLE;
          else begin
            cnt_q <= cnt_q - 8'd1;
            addr_q <= autoinc_q ? addr_q + (32'd1 << size_q) : addr_q;
            state <= CHECK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
